serial_subtractor: RTL and testbench

- Bit-serial W-bit subtractor: computes A - B - borrow_in, LSB first, one bit per clock.
- Built around the team's existing single-bit full_subtractor cell; a borrow flip-flop closes the loop between bits.
- Sits directly downstream of the full subtractor cell: it consumes the cell's Diff/Borr outputs and sequences operands into it.
- Intended for area-constrained datapaths where a W-bit ripple subtractor is too large.

---
 rtl/serial_sub_pkg.sv | 20 ++
 rtl/full_subtractor.sv | 19 +
 rtl/serial_subtractor.sv | 173 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared definitions for the bit-serial subtractor.
//   - state_e    : FSM encodings (IDLE / SHIFT / DONE)
//   - DEFAULT_W  : default operand width
//   - cnt_width(): bit-counter width for a given operand width (minimum 1)
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam int DEFAULT_W = 8;

  // $clog2(1) is 0, but a zero-width counter is not representable.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: single-bit full subtractor cell, computes a - b - in.
// Ports:
//   Diff : output, difference bit
//   Borr : output, borrow out (1 when a < b + in)
//   a    : input, minuend bit
//   b    : input, subtrahend bit
//   in   : input, borrow in
module full_subtractor (
  output logic Diff,
  output logic Borr,
  input  logic a,
  input  logic b,
  input  logic in
);

  assign Diff = a ^ b ^ in;
  assign Borr = (~a & b) | (~a & in) | (b & in);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial W-bit subtractor computing A - B - borrow_in,
// LSB first, one bit per clock, using a single full_subtractor cell and a
// borrow flip-flop between bits.
// Ports:
//   clk        : input, rising-edge clock
//   rst_n      : input, asynchronous active-low reset
//   start      : input, request; sampled only in IDLE or DONE
//   a_in       : input [W], minuend, captured on accepted start
//   b_in       : input [W], subtrahend, captured on accepted start
//   borrow_in  : input, initial borrow, captured on accepted start
//   busy       : output, high while bits are being processed
//   done       : output, one-cycle pulse when the result becomes valid
//   diff_out   : output [W], result, held until the next operation completes
//   borrow_out : output, final borrow (1 = A < B + borrow_in, unsigned)
//   ovf        : output, signed overflow of the subtraction; only present
//                when SERIAL_SUBTRACTOR_OVERFLOW_EN is defined
// Optional feature macro: SERIAL_SUBTRACTOR_OVERFLOW_EN
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         borrow_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff_out,
  output logic         borrow_out
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = cnt_width(W);

  state_e         state_q, state_d;
  logic [W-1:0]   a_sr_q, a_sr_d;
  logic [W-1:0]   b_sr_q, b_sr_d;
  logic [W-1:0]   res_sr_q, res_sr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           borrow_q, borrow_d;
  logic [W-1:0]   diff_out_q, diff_out_d;
  logic           borrow_out_q, borrow_out_d;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic           a_sign_q, a_sign_d;
  logic           b_sign_q, b_sign_d;
  logic           ovf_q, ovf_d;
`endif

  logic           cell_diff;
  logic           cell_borr;
  logic           last_bit;
  logic           accept;
  logic [W-1:0]   res_shifted;

  full_subtractor u_cell (
    .Diff (cell_diff),
    .Borr (cell_borr),
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .in   (borrow_q)
  );

  assign last_bit = (cnt_q == CW'(W - 1));
  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));

  // New difference bit enters at the MSB so that after W shifts the LSB
  // computed first lands at bit 0. Shift form keeps W=1 legal.
  assign res_shifted = (res_sr_q >> 1) | (W'(cell_diff) << (W - 1));

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      res_sr_q     <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      diff_out_q   <= '0;
      borrow_out_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      a_sign_q     <= 1'b0;
      b_sign_q     <= 1'b0;
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      res_sr_q     <= res_sr_d;
      cnt_q        <= cnt_d;
      borrow_q     <= borrow_d;
      diff_out_q   <= diff_out_d;
      borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      a_sign_q     <= a_sign_d;
      b_sign_q     <= b_sign_d;
      ovf_q        <= ovf_d;
`endif
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE, DONE: state_d = accept ? SHIFT : IDLE;
      SHIFT:      state_d = last_bit ? DONE : SHIFT;
      default:    state_d = IDLE;  // unused encoding recovers to IDLE
    endcase
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    res_sr_d     = res_sr_q;
    cnt_d        = cnt_q;
    borrow_d     = borrow_q;
    diff_out_d   = diff_out_q;
    borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    a_sign_d     = a_sign_q;
    b_sign_d     = b_sign_q;
    ovf_d        = ovf_q;
`endif
    if (accept) begin
      a_sr_d   = a_in;
      b_sr_d   = b_in;
      res_sr_d = '0;
      cnt_d    = '0;
      borrow_d = borrow_in;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      // Operand sign bits are shifted out during SHIFT, so keep copies.
      a_sign_d = a_in[W-1];
      b_sign_d = b_in[W-1];
`endif
    end else if (state_q == SHIFT) begin
      a_sr_d   = a_sr_q >> 1;
      b_sr_d   = b_sr_q >> 1;
      res_sr_d = res_shifted;
      cnt_d    = cnt_q + CW'(1);
      borrow_d = cell_borr;
      if (last_bit) begin
        diff_out_d   = res_shifted;
        borrow_out_d = cell_borr;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        // The final cell_diff is the result sign bit.
        ovf_d = (a_sign_q != b_sign_q) && (cell_diff != a_sign_q);
`endif
      end
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  assign diff_out   = diff_out_q;
  assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor.
// Instantiates a W=8 DUT for the main sequence and a W=1 DUT for the
// exhaustive single-bit sweep. Expected results come from an arithmetic
// model and are queued at issue time, then popped when done is seen.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bo;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         borrow_in;
  logic         busy, done;
  logic [W-1:0] diff_out;
  logic         borrow_out;
  logic         ovf;

  logic         s1_start;
  logic [0:0]   s1_a, s1_b;
  logic         s1_bin;
  logic         s1_busy, s1_done;
  logic [0:0]   s1_diff;
  logic         s1_bo;
  logic         s1_ovf;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff_out   (diff_out),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    .ovf        (ovf)
`endif
  );

  serial_subtractor #(.W(1)) dut_w1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (s1_start),
    .a_in       (s1_a),
    .b_in       (s1_b),
    .borrow_in  (s1_bin),
    .busy       (s1_busy),
    .done       (s1_done),
    .diff_out   (s1_diff),
    .borrow_out (s1_bo)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    .ovf        (s1_ovf)
`endif
  );

`ifndef SERIAL_SUBTRACTOR_OVERFLOW_EN
  assign ovf    = 1'b0;
  assign s1_ovf = 1'b0;
`endif

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bin);
    logic [W:0] r;
    exp_t e;
    r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    e.diff = r[W-1:0];
    e.bo   = r[W];
    e.ov   = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin);
    a_in      = a;
    b_in      = b;
    borrow_in = bin;
    start     = 1'b1;
    sb_q.push_back(model(a, b, bin));
    tick();
    start_cyc = cyc;
    start     = 1'b0;
    $display("issue a=%02h b=%02h bin=%0d at cycle %0d", a, b, bin, start_cyc);
  endtask

  task automatic wait_result(input string tag, output int busy_n);
    int n;
    exp_t e;
    busy_n = 0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_n++;
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(cyc - start_cyc), 32'(W));
    check({tag, "_done"}, 32'(done), 32'(1));
    check({tag, "_busy_in_done"}, 32'(busy), 32'(0));
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'(1));
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_diff"}, 32'(diff_out), 32'(e.diff));
      check({tag, "_borrow"}, 32'(borrow_out), 32'(e.bo));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(e.ov));
`endif
      $display("%s: diff=%02h borrow=%0d ovf=%0d (exp %02h %0d %0d)",
               tag, diff_out, borrow_out, ovf, e.diff, e.bo, e.ov);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    int n;
    int hits;
    int r;

    rst_n     = 1'b0;
    start     = 1'b0;
    a_in      = '0;
    b_in      = '0;
    borrow_in = 1'b0;
    s1_start  = 1'b0;
    s1_a      = '0;
    s1_b      = '0;
    s1_bin    = 1'b0;

    // Reset state.
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_diff", 32'(diff_out), 32'(0));
    check("rst_borrow", 32'(borrow_out), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));
    #12;
    rst_n = 1'b1;
    tick();

    // 0x5A - 0x3C: latency, busy length, single-cycle done.
    issue(8'h5A, 8'h3C, 1'b0);
    wait_result("t1", busy_n);
    check("t1_busy_cycles", 32'(busy_n), 32'(W));
    tick();
    check("t1_done_one_cycle", 32'(done), 32'(0));

    // 0x00 - 0x01 -> all ones with borrow.
    issue(8'h00, 8'h01, 1'b0);
    wait_result("t2", busy_n);

    // 0x10 - 0x0F - 1 then back-to-back start in the DONE cycle.
    issue(8'h10, 8'h0F, 1'b1);
    wait_result("t3a", busy_n);
    issue(8'h80, 8'h01, 1'b0);
    wait_result("t3b", busy_n);
    tick();

    // Start re-pulsed during SHIFT must be ignored.
    issue(8'h33, 8'h11, 1'b0);
    tick();
    tick();
    a_in  = 8'hFF;
    b_in  = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_result("t4", busy_n);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) hits++;
    end
    check("t4_single_done", 32'(hits), 32'(0));
    check("t4_sb_empty", 32'(sb_q.size()), 32'(0));

    // Asynchronous reset in the middle of SHIFT.
    issue(8'hAA, 8'h55, 1'b0);
    tick();
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'(0));
    check("t5_rst_done", 32'(done), 32'(0));
    check("t5_rst_diff", 32'(diff_out), 32'(0));
    check("t5_rst_borrow", 32'(borrow_out), 32'(0));
    check("t5_rst_ovf", 32'(ovf), 32'(0));
    void'(sb_q.pop_back());
    #2;
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) hits++;
    end
    check("t5_idle_after_rst", 32'(hits), 32'(0));
    issue(8'hAA, 8'h55, 1'b0);
    wait_result("t5", busy_n);

    // Boundary operands.
    issue(8'hC3, 8'hC3, 1'b0);
    wait_result("t6_equal", busy_n);
    issue(8'h00, 8'h00, 1'b1);
    wait_result("t6_zero_minus_one", busy_n);
    issue(8'h7F, 8'hFF, 1'b0);
    wait_result("t6_misc", busy_n);

    // Exhaustive W=1 sweep.
    for (int v = 0; v < 8; v++) begin
      s1_a     = 1'(v >> 2);
      s1_b     = 1'(v >> 1);
      s1_bin   = 1'(v);
      s1_start = 1'b1;
      tick();
      s1_start = 1'b0;
      n = 0;
      while (s1_done !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      r = int'(s1_a) - int'(s1_b) - int'(s1_bin);
      check($sformatf("w1_%0d_latency", v), 32'(n), 32'(1));
      check($sformatf("w1_%0d_diff", v), 32'(s1_diff), 32'(r & 1));
      check($sformatf("w1_%0d_borrow", v), 32'(s1_bo), 32'(r < 0));
      $display("w1 a=%0d b=%0d bin=%0d -> diff=%0d borrow=%0d",
               s1_a, s1_b, s1_bin, s1_diff, s1_bo);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
